mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the pipelined CPU's EX stage. It executes MULT, MULTU, DIV and DIVU over WIDTH-parametrised operands and writes a HI/LO result pair. It sits beside the single-cycle ALU: operands come from the forwarded rs/rt paths. It raises a stall request so hazard detection can freeze PC and IF/ID while a HI/LO reader, or a second multiply/divide, waits.

## Interface
- WIDTH, 32, operand and result width; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk_i  in  1  clock; every flop is rising-edge.
- rst_i  in  1  reset, asynchronous and active-high.
- start_i  in  1  request a new operation; the operands and op_i are valid this cycle.
- op_i  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- data1_i  in  WIDTH  rs operand (multiplicand or dividend).
- data2_i  in  WIDTH  rt operand (multiplier or divisor).
- flush_i  in  1  abort any in-flight operation.
- hilo_rd_i  in  1  the instruction in ID reads HI or LO.
- busy_o  out  1  an operation is in flight.
- done_o  out  1  one-cycle completion pulse.
- stall_o  out  1  stall request to hazard detection.
- hi_o  out  WIDTH  HI register: product upper half, or remainder.
- lo_o  out  WIDTH  LO register: product lower half, or quotient.
- div_zero_o  out  1  divide by zero; pulses together with done_o.

## Operation
States:
- IDLE: start_i with flush_i low → latch operands, set cnt=0, go to RUN.
  - Signed ops latch absolute values and record the sign bits.
  - The absolute value of -2^(WIDTH-1) is 2^(WIDTH-1) as an unsigned value.
- RUN: one radix-2 step per cycle.
  - Multiply is shift-add into a 2·WIDTH accumulator.
  - Divide is restoring shift-subtract.
  - cnt increments each step; after the step with cnt==WIDTH-1 the state goes to DONE.
- DONE: apply sign correction, register hi_o/lo_o, pulse done_o, go to IDLE.

Sign correction:
- MULT: negate the 2·WIDTH product if the operand signs differ.
- DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- DIV of -2^(WIDTH-1) by -1: lo=0x80000000 (wraps), hi=0.

Divide by zero (divisor 0, signed or unsigned):
- lo = all ones; hi = data1 exactly as latched, with no sign handling.
- div_zero_o=1 with done_o.
- Takes the full latency; the iterations still run.

Control rules:
- busy_o = (state != IDLE).
- start_i while busy_o is ignored; the caller must hold it until accepted.
- stall_o = busy_o & (hilo_rd_i | start_i).
- flush_i in RUN or DONE: go to IDLE on the next edge; hi_o, lo_o unchanged; no done_o pulse.
- flush_i and start_i together in IDLE: flush wins and the start is dropped.
- hi_o and lo_o hold their value until the next completion.

Reset values: state IDLE; busy_o, done_o, stall_o, div_zero_o = 0; hi_o = lo_o = 0; cnt = 0.

## Timing
- start_i sampled at edge E0 → RUN from E0.
- Steps occur at edges E1…E_WIDTH; DONE is the cycle after E_WIDTH.
- At E_(WIDTH+1): hi_o/lo_o update; done_o and div_zero_o are high for exactly that following cycle; busy_o is already 0.
- A new start_i is accepted in that same done_o cycle (back-to-back issue), giving a throughput of one operation per WIDTH+2 cycles.
- WIDTH=32: done_o is high 33 cycles after the start edge.
- hi_o/lo_o are registered; no combinational path from the inputs to hi_o/lo_o.
- stall_o is combinational from hilo_rd_i and start_i.
- Asserting rst_i in any cycle forces the reset values immediately, without waiting for a clock edge.

## Configuration
- MDU_DIV_EN defined: DIV and DIVU are supported as described above.
- MDU_DIV_EN undefined:
  - The divider datapath and the sign logic for the remainder are removed.
  - div_zero_o is tied to 0.
  - start_i with op_i[1]=1 is ignored: the unit stays in IDLE, gives no done_o, and leaves hi_o/lo_o unchanged.
  - The multiply behaviour and its timing are identical.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF, WIDTH=32 → hi=0xFFFFFFFE, lo=0x00000001; done_o high exactly 33 cycles after the start edge; busy_o high for the 32 cycles in between.
- MULT -3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV -7÷2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000÷0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 7÷0 → lo=0xFFFFFFFF, hi=0x00000007, div_zero_o=1 in the done_o cycle. Repeat with MDU_DIV_EN undefined → no done_o; hi_o/lo_o keep their previous values.
- Start MULTU 5×5; assert flush_i at cycle 10 → busy_o low after the next edge; no done_o; hi/lo keep their previous values. Then start_i with flush_i together in IDLE → stays IDLE.
- During an operation: hilo_rd_i=1 → stall_o=1; a second start_i is ignored and raises stall_o; back-to-back start in the done_o cycle is accepted.
- Assert rst_i at cycle 15 of a division → all outputs 0 immediately, without a clock edge; state is IDLE.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit producing a HI/LO pair.
// Optional divider enabled by defining MDU_DIV_EN; otherwise only MULT/MULTU are executed.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    input  logic             hilo_rd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             r_state, w_state_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_a;
    logic               r_sign1, r_sign2;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done, r_dz;

    logic               w_op_ok, w_accept;
    logic [WIDTH-1:0]   w_abs1, w_abs2;
    logic [2*WIDTH-1:0] w_acc_init, w_step, w_mul_step, w_prod;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_hi_d, w_lo_d;
    logic               w_dz_d;

`ifdef MDU_DIV_EN
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     w_rem_sh, w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_step;
    logic [WIDTH-1:0]   w_quo, w_rem;
    assign w_op_ok = 1'b1;
`else
    assign w_op_ok = ~op_i[1];
`endif

    assign w_accept = start_i & ~flush_i & w_op_ok;
    assign w_abs1   = (~op_i[0] & data1_i[WIDTH-1]) ? -data1_i : data1_i;
    assign w_abs2   = (~op_i[0] & data2_i[WIDTH-1]) ? -data2_i : data2_i;

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mul_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    assign w_prod     = (r_sign1 ^ r_sign2) ? -r_acc : r_acc;

`ifdef MDU_DIV_EN
    // Divide: accumulator is {partial remainder, dividend bits / quotient bits}.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_div_step = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_ge};
    assign w_quo      = (r_sign1 ^ r_sign2) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem      = r_sign1 ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        w_acc_init = {{WIDTH{1'b0}}, w_abs2};
        w_step     = w_mul_step;
        w_hi_d     = w_prod[2*WIDTH-1:WIDTH];
        w_lo_d     = w_prod[WIDTH-1:0];
        w_dz_d     = 1'b0;
`ifdef MDU_DIV_EN
        if (op_i[1]) w_acc_init = {{WIDTH{1'b0}}, w_abs1};
        if (r_op[1]) begin
            w_step = w_div_step;
            if (r_b == '0) begin
                // Divide by zero reports the original dividend, not its magnitude.
                w_hi_d = r_sign1 ? -r_a : r_a;
                w_lo_d = '1;
                w_dz_d = 1'b1;
            end else begin
                w_hi_d = w_rem;
                w_lo_d = w_quo;
            end
        end
`endif
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StRun;
            StRun: begin
                if (flush_i)                                w_state_d = StIdle;
                else if (r_cnt == CNT_W'(WIDTH - 1))        w_state_d = StDone;
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
`ifdef MDU_DIV_EN
            r_op    <= '0;
            r_b     <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            case (r_state)
                StIdle: if (w_accept) begin
                    r_cnt   <= '0;
                    r_acc   <= w_acc_init;
                    r_a     <= w_abs1;
                    r_sign1 <= ~op_i[0] & data1_i[WIDTH-1];
                    r_sign2 <= ~op_i[0] & data2_i[WIDTH-1];
`ifdef MDU_DIV_EN
                    r_op    <= op_i;
                    r_b     <= w_abs2;
`endif
                end
                StRun: if (!flush_i) begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                StDone: if (!flush_i) begin
                    r_hi   <= w_hi_d;
                    r_lo   <= w_lo_d;
                    r_done <= 1'b1;
                    r_dz   <= w_dz_d;
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (r_state != StIdle);
    assign stall_o    = busy_o & (hilo_rd_i | start_i);
    assign done_o     = r_done;
    assign div_zero_o = r_dz;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed, table-driven bench for mdu_iter; follows MDU_DIV_EN to pick divide expectations.
module tb_mdu_iter;
    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, hilo_rd = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] d1 = '0, d2 = '0;
    logic         busy, done, stall, dz;
    logic [W-1:0] hi, lo;

    int checks = 0, errors = 0;
    logic [W-1:0] prev_hi = '0, prev_lo = '0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .data1_i(d1), .data2_i(d2),
        .flush_i(flush), .hilo_rd_i(hilo_rd), .busy_o(busy), .done_o(done), .stall_o(stall),
        .hi_o(hi), .lo_o(lo), .div_zero_o(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op = o; d1 = a; d2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the number of edges until done_o is seen (0 on timeout).
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit bok;
        issue(v.op, v.a, v.b);
        if (DivEn || !v.op[1]) begin
            chk($sformatf("v%0d busy_after_start", idx), 64'(busy), 64'd1);
            wait_done(lat, bok);
            chk($sformatf("v%0d latency", idx), 64'(lat), 64'd33);
            chk($sformatf("v%0d busy_during", idx), 64'(bok), 64'd1);
            chk($sformatf("v%0d busy_at_done", idx), 64'(busy), 64'd0);
            chk($sformatf("v%0d hi", idx), 64'(hi), 64'(v.hi));
            chk($sformatf("v%0d lo", idx), 64'(lo), 64'(v.lo));
            chk($sformatf("v%0d div_zero", idx), 64'(dz), 64'(v.dz));
            prev_hi = v.hi;
            prev_lo = v.lo;
        end else begin
            chk($sformatf("v%0d ignored_busy", idx), 64'(busy), 64'd0);
            wait_done(lat, bok);
            chk($sformatf("v%0d ignored_no_done", idx), 64'(lat), 64'd0);
            chk($sformatf("v%0d ignored_hi", idx), 64'(hi), 64'(prev_hi));
            chk($sformatf("v%0d ignored_lo", idx), 64'(lo), 64'(prev_lo));
        end
    endtask

    initial begin
        int lat;
        bit bok;
        //        op     a             b             hi            lo            dz
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[6]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[7]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{2'b00, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};
        vecs[10] = '{2'b00, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};

        #12;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset dz", 64'(dz), 64'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Flush mid-run: no completion, results untouched.
        issue(2'b01, 32'd5, 32'd5);
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush busy_low", 64'(busy), 64'd0);
        wait_done(lat, bok);
        chk("flush no_done", 64'(lat), 64'd0);
        chk("flush hi_kept", 64'(hi), 64'(prev_hi));
        chk("flush lo_kept", 64'(lo), 64'(prev_lo));

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        op = 2'b01; d1 = 32'd5; d2 = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("idle_flush busy", 64'(busy), 64'd0);
        wait_done(lat, bok);
        chk("idle_flush no_done", 64'(lat), 64'd0);

        // Stall behaviour and back-to-back issue from the done cycle.
        issue(2'b01, 32'd3, 32'd3);
        repeat (4) @(posedge clk);
        #1 hilo_rd = 1'b1;
        #1 chk("stall hilo_rd", 64'(stall), 64'd1);
        hilo_rd = 1'b0;
        #1 chk("stall none", 64'(stall), 64'd0);
        op = 2'b01; d1 = 32'd4; d2 = 32'd4; start = 1'b1;
        #1 chk("stall second_start", 64'(stall), 64'd1);
        wait_done(lat, bok);
        chk("b2b first_done", 64'(done), 64'd1);
        chk("b2b first_lo", 64'(lo), 64'd9);
        chk("b2b no_stall_in_done", 64'(stall), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b accepted", 64'(busy), 64'd1);
        wait_done(lat, bok);
        chk("b2b latency", 64'(lat), 64'd33);
        chk("b2b second_hi", 64'(hi), 64'd0);
        chk("b2b second_lo", 64'(lo), 64'd16);

        // Asynchronous reset in the middle of an operation.
        issue(DivEn ? 2'b11 : 2'b01, 32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        #1 hilo_rd = 1'b1; start = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst stall", 64'(stall), 64'd0);
        chk("async_rst done", 64'(done), 64'd0);
        chk("async_rst hi", 64'(hi), 64'd0);
        chk("async_rst lo", 64'(lo), 64'd0);
        chk("async_rst dz", 64'(dz), 64'd0);
        @(negedge clk);
        rst = 1'b0; hilo_rd = 1'b0; start = 1'b0;
        @(posedge clk);
        #1 chk("after_rst idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
